// File: rtl/io_bus_arbiter.sv
// Arbitrates NUM_REQUESTERS cores onto one non-cached I/O bus, one transaction per 3 cycles.
// Define IO_ARB_ROUND_ROBIN_EN for a round-robin pointer; fixed lowest-index priority otherwise.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_bus_arbiter_pkg;
    typedef logic [3:0] core_id_t;
    typedef logic [1:0] thread_idx_t;

    typedef struct packed {
        logic        store;
        thread_idx_t thread_idx;
        logic [31:0] address;
        logic [31:0] value;
    } ioreq_packet_t;

    typedef struct packed {
        core_id_t    core;
        thread_idx_t thread_idx;
        logic [31:0] read_value;
    } iorsp_packet_t;
endpackage

interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    modport master(output write_en, read_en, address, write_data, input read_data);
    modport slave(input write_en, read_en, address, write_data, output read_data);
endinterface

module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQUESTERS = `NUM_CORES
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQUESTERS-1:0] ioreq_valid,
    input  ioreq_packet_t             ioreq [NUM_REQUESTERS],
    output logic [NUM_REQUESTERS-1:0] ioreq_ack,
    output logic                      iorsp_valid,
    output iorsp_packet_t             iorsp,
    io_bus_interface.master           io_bus
);
    localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;

    state_t            state;
    logic [IDX_W-1:0]  grant_idx;
    logic              req_store;
    thread_idx_t       req_thread;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;

`ifdef IO_ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  cand_idx;
    int                cand;

    // First valid index at or after the pointer, wrapping past the top.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_REQUESTERS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQUESTERS) cand = cand - NUM_REQUESTERS;
            cand_idx = IDX_W'(cand);
            if (!sel_found && ioreq_valid[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end
`else
    always_comb begin
        sel_idx   = '0;
        sel_found = |ioreq_valid;
        for (int k = NUM_REQUESTERS - 1; k >= 0; k--) begin
            if (ioreq_valid[k]) sel_idx = IDX_W'(k);
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            grant_idx         <= '0;
            req_store         <= 1'b0;
            req_thread        <= '0;
            ioreq_ack         <= '0;
            iorsp_valid       <= 1'b0;
            iorsp             <= '0;
            io_bus.write_en   <= 1'b0;
            io_bus.read_en    <= 1'b0;
            io_bus.address    <= '0;
            io_bus.write_data <= '0;
`ifdef IO_ARB_ROUND_ROBIN_EN
            rr_ptr            <= '0;
`endif
        end else begin
            ioreq_ack         <= '0;
            iorsp_valid       <= 1'b0;
            io_bus.write_en   <= 1'b0;
            io_bus.read_en    <= 1'b0;
            io_bus.address    <= '0;
            io_bus.write_data <= '0;
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_idx         <= sel_idx;
                        req_store         <= ioreq[sel_idx].store;
                        req_thread        <= ioreq[sel_idx].thread_idx;
                        ioreq_ack         <= NUM_REQUESTERS'(1) << sel_idx;
                        io_bus.write_en   <= ioreq[sel_idx].store;
                        io_bus.read_en    <= !ioreq[sel_idx].store;
                        io_bus.address    <= ioreq[sel_idx].address;
                        // Loads leave write_data at zero; only stores carry a payload.
                        io_bus.write_data <= ioreq[sel_idx].store ? ioreq[sel_idx].value : 32'h0;
`ifdef IO_ARB_ROUND_ROBIN_EN
                        rr_ptr            <= (sel_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : sel_idx + 1'b1;
`endif
                        state             <= ISSUE;
                    end
                end
                ISSUE: state <= RESPOND;
                RESPOND: begin
                    iorsp_valid      <= 1'b1;
                    iorsp.core       <= core_id_t'(grant_idx);
                    iorsp.thread_idx <= req_thread;
                    iorsp.read_value <= req_store ? 32'h0 : io_bus.read_data;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Scoreboard bench for io_bus_arbiter: directed bursts push expected grants/responses,
// a negedge monitor pops and compares whenever ack or iorsp_valid appears.
module tb_io_bus_arbiter;
    import io_bus_arbiter_pkg::*;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    ioreq_valid;
    ioreq_packet_t   ioreq [N];
    logic [N-1:0]    ioreq_ack;
    logic            iorsp_valid;
    iorsp_packet_t   iorsp;

    io_bus_interface bus();

    io_bus_arbiter #(.NUM_REQUESTERS(N)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ioreq_valid(ioreq_valid),
        .ioreq      (ioreq),
        .ioreq_ack  (ioreq_ack),
        .iorsp_valid(iorsp_valid),
        .iorsp      (iorsp),
        .io_bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic        store;
        logic [1:0]  thr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rval;
        int          cyc;
    } exp_t;

    exp_t ack_q[$];
    exp_t rsp_q[$];
    exp_t mon_e;
    int   remaining[N];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   s;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bus_read(input logic [31:0] a);
        case (a)
            32'hFFFF0004: return 32'h0000_1234;
            32'hFFFF0010: return 32'h1111_0000;
            32'hFFFF0020: return 32'h2222_0000;
            default:      return 32'h0BAD_F00D;
        endcase
    endfunction

    // Slave returns read data one cycle after read_en; garbage otherwise.
    always @(posedge clk) bus.read_data <= bus.read_en ? bus_read(bus.address) : 32'hBAD0_0BAD;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_txn(input int idx, input logic store, input logic [1:0] thr,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rval, input int ack_cyc, input bit with_rsp);
        exp_t e;
        e.idx = idx; e.store = store; e.thr = thr; e.addr = addr;
        e.wdata = wdata; e.rval = rval; e.cyc = ack_cyc;
        ack_q.push_back(e);
        if (with_rsp) begin
            e.cyc = ack_cyc + 2;
            rsp_q.push_back(e);
        end
    endtask

    task automatic present(input int idx, input logic store, input logic [1:0] thr,
                           input logic [31:0] addr, input logic [31:0] val, input int count);
        ioreq[idx].store      = store;
        ioreq[idx].thread_idx = thr;
        ioreq[idx].address    = addr;
        ioreq[idx].value      = val;
        remaining[idx]        = count;
        ioreq_valid[idx]      = 1'b1;
    endtask

    task automatic wait_drain(input string name);
        bit done = 0;
        for (int i = 0; i < 80 && !done; i++) begin
            @(negedge clk);
            done = (ack_q.size() == 0) && (rsp_q.size() == 0) &&
                   (remaining[0] == 0) && (remaining[1] == 0) &&
                   (remaining[2] == 0) && (remaining[3] == 0);
        end
        check({name, "_drained"}, 64'(done), 64'd1);
        ack_q.delete();
        rsp_q.delete();
        for (int i = 0; i < N; i++) begin
            remaining[i]   = 0;
            ioreq_valid[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 64'(ioreq_ack), 64'd0);
        check({tag, "_iorsp_valid"}, 64'(iorsp_valid), 64'd0);
        check({tag, "_iorsp"}, 64'(iorsp), 64'd0);
        check({tag, "_write_en"}, 64'(bus.write_en), 64'd0);
        check({tag, "_read_en"}, 64'(bus.read_en), 64'd0);
        check({tag, "_address"}, 64'(bus.address), 64'd0);
        check({tag, "_write_data"}, 64'(bus.write_data), 64'd0);
    endtask

    // Monitor plus requester model: a requester drops or re-presents after each ack.
    always @(negedge clk) begin
        logic [N-1:0] exp_ack;
        if (ioreq_ack != '0) begin
            if (ack_q.size() == 0) begin
                check("unexpected_ack", 64'(ioreq_ack), 64'd0);
            end else begin
                mon_e = ack_q.pop_front();
                exp_ack = '0;
                exp_ack[mon_e.idx] = 1'b1;
                check("ack_vec", 64'(ioreq_ack), 64'(exp_ack));
                check("write_en", 64'(bus.write_en), 64'(mon_e.store));
                check("read_en", 64'(bus.read_en), 64'(!mon_e.store));
                check("address", 64'(bus.address), 64'(mon_e.addr));
                check("write_data", 64'(bus.write_data), 64'(mon_e.store ? mon_e.wdata : 32'h0));
                check("ack_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end else begin
            check("idle_strobes", 64'({bus.write_en, bus.read_en}), 64'd0);
            check("idle_addr_data", {bus.address, bus.write_data}, 64'd0);
        end
        if (iorsp_valid) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_iorsp", 64'(iorsp_valid), 64'd0);
            end else begin
                mon_e = rsp_q.pop_front();
                check("rsp_core", 64'(iorsp.core), 64'(mon_e.idx));
                check("rsp_thread", 64'(iorsp.thread_idx), 64'(mon_e.thr));
                check("rsp_value", 64'(iorsp.read_value), 64'(mon_e.rval));
                check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (ioreq_ack[i] && remaining[i] > 0) begin
                remaining[i] = remaining[i] - 1;
                if (remaining[i] == 0) ioreq_valid[i] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        ioreq_valid = '0;
        for (int i = 0; i < N; i++) begin
            ioreq[i]     = '0;
            remaining[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Arbitration policy with several requesters held valid.
        @(negedge clk);
        s = cyc;
`ifdef IO_ARB_ROUND_ROBIN_EN
        expect_txn(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0,  32'h1111_0000, s + 1,  1);
        expect_txn(1, 1'b1, 2'd1, 32'hFFFF0100, 32'h11, 32'h0,         s + 4,  1);
        expect_txn(2, 1'b0, 2'd2, 32'hFFFF0020, 32'h0,  32'h2222_0000, s + 7,  1);
        expect_txn(3, 1'b1, 2'd3, 32'hFFFF0300, 32'h33, 32'h0,         s + 10, 1);
        expect_txn(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0,  32'h1111_0000, s + 13, 1);
        present(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0,  2);
        present(1, 1'b1, 2'd1, 32'hFFFF0100, 32'h11, 1);
        present(2, 1'b0, 2'd2, 32'hFFFF0020, 32'h0,  1);
        present(3, 1'b1, 2'd3, 32'hFFFF0300, 32'h33, 1);
        wait_drain("round_robin");
`else
        expect_txn(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0, 32'h1111_0000, s + 1,  1);
        expect_txn(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0, 32'h1111_0000, s + 4,  1);
        expect_txn(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0, 32'h1111_0000, s + 7,  1);
        expect_txn(2, 1'b0, 2'd2, 32'hFFFF0020, 32'h0, 32'h2222_0000, s + 10, 1);
        present(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0, 3);
        present(2, 1'b0, 2'd2, 32'hFFFF0020, 32'h0, 1);
        wait_drain("fixed_priority");
`endif

        // Single load.
        @(negedge clk);
        s = cyc;
        expect_txn(1, 1'b0, 2'd2, 32'hFFFF0004, 32'h0, 32'h0000_1234, s + 1, 1);
        present(1, 1'b0, 2'd2, 32'hFFFF0004, 32'h0, 1);
        wait_drain("single_load");

        // Single store.
        @(negedge clk);
        s = cyc;
        expect_txn(0, 1'b1, 2'd1, 32'hFFFF0100, 32'hA5, 32'h0, s + 1, 1);
        present(0, 1'b1, 2'd1, 32'hFFFF0100, 32'hA5, 1);
        wait_drain("single_store");

        // Grant req2 alone, leaving a round-robin pointer at 3.
        @(negedge clk);
        s = cyc;
        expect_txn(2, 1'b1, 2'd2, 32'hFFFF0200, 32'h22, 32'h0, s + 1, 1);
        present(2, 1'b1, 2'd2, 32'hFFFF0200, 32'h22, 1);
        wait_drain("ptr_setup");

        // req3 and req0 together.
        @(negedge clk);
        s = cyc;
`ifdef IO_ARB_ROUND_ROBIN_EN
        expect_txn(3, 1'b1, 2'd3, 32'hFFFF0300, 32'h33, 32'h0,         s + 1, 1);
        expect_txn(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0,  32'h1111_0000, s + 4, 1);
`else
        expect_txn(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0,  32'h1111_0000, s + 1, 1);
        expect_txn(3, 1'b1, 2'd3, 32'hFFFF0300, 32'h33, 32'h0,         s + 4, 1);
`endif
        present(3, 1'b1, 2'd3, 32'hFFFF0300, 32'h33, 1);
        present(0, 1'b0, 2'd0, 32'hFFFF0010, 32'h0,  1);
        wait_drain("ptr_wrap");

        // Reset during RESPOND drops the transaction.
        @(negedge clk);
        s = cyc;
        expect_txn(2, 1'b0, 2'd2, 32'hFFFF0020, 32'h0, 32'h0, s + 1, 0);
        present(2, 1'b0, 2'd2, 32'hFFFF0020, 32'h0, 1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check_all_zero("mid_reset");
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_iorsp_valid", 64'(iorsp_valid), 64'd0);
            check("post_reset_ack", 64'(ioreq_ack), 64'd0);
        end
        check("mid_reset_ack_seen", 64'(ack_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
